// File: rtl/seq_binary_to_bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits needed to hold values 0..n-1; evaluated at elaboration for counter sizing.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_binary_to_bcd_if.sv
// Handshake and result bus between the datapath, the converter and the display drivers.
// The blank vector exists only when BCD_BLANK_EN is defined.
interface seq_binary_to_bcd_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  ovf;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif

    // Producer/consumer side: drives operands, accepts results.
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  bcd,
        input  neg,
        input  ovf
`ifdef BCD_BLANK_EN
        ,
        input  blank
`endif
    );

    // Converter side.
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output bcd,
        output neg,
        output ovf
`ifdef BCD_BLANK_EN
        ,
        output blank
`endif
    );

endinterface

// File: rtl/seq_binary_to_bcd_digit_adj.sv
// One BCD digit of the double-dabble chain: adds 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    always_comb begin
        digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
    end

endmodule

// File: rtl/seq_binary_to_bcd.sv
// Shift-and-add-3 binary-to-BCD converter, one bit per clock; optional blank vector under BCD_BLANK_EN.
// Latency: result valid WIDTH+1 cycles after the accept cycle; one word per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module seq_binary_to_bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_binary_to_bcd_if.slave bus
);

    localparam int CW = clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;

    logic [BW-1:0]     bcd_adj;
    logic [WIDTH-1:0]  in_negated;
    logic [WIDTH-1:0]  in_mag;
    logic              in_is_neg;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (bcd_q[4*gi +: 4]),
                .digit_o (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is its true magnitude unsigned.
    always_comb begin
        in_is_neg  = (SIGNED != 0) && bus.in_data[WIDTH-1];
        in_negated = ~bus.in_data + {{(WIDTH-1){1'b0}}, 1'b1};
        in_mag     = in_is_neg ? in_negated : bus.in_data;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mag_d   = in_mag;
                    neg_d   = in_is_neg;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d   = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
                mag_d   = {mag_q[WIDTH-2:0], 1'b0};
                ovf_d   = ovf_q | bcd_adj[BW-1];
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.bcd       = bcd_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              blank_nz;

    // Scan from the top digit down; a digit is blank until the first nonzero digit is met.
    always_comb begin
        blank_nz = 1'b0;
        blank_d  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            blank_nz   = blank_nz | (bcd_d[4*k +: 4] != 4'd0);
            blank_d[k] = ~blank_nz && (k != 0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign bus.blank = blank_q;
`endif

endmodule
